// File: rtl/roll_recorder_if.sv
// Bus between the dice generator/UI and roll_recorder: live value, roll status,
// browse controls and everything the recorder shows back to the user.
interface roll_recorder_if #(
  parameter int DEPTH = 8
);
  localparam int IW = $clog2(DEPTH);

  logic [3:0]    i_value;
  logic          i_busy;
  logic          i_recall;
  logic          i_exit;
  logic [3:0]    o_display;
  logic [IW-1:0] o_index;
  logic [IW:0]   o_count;
  logic          o_browse;
  logic          o_new;
  logic [3:0]    o_max;

  modport master (
    output i_value, i_busy, i_recall, i_exit,
    input  o_display, o_index, o_count, o_browse, o_new, o_max
  );

  modport slave (
    input  i_value, i_busy, i_recall, i_exit,
    output o_display, o_index, o_count, o_browse, o_new, o_max
  );
endinterface

// File: rtl/roll_recorder.sv
// Records the value at the end of each roll in a DEPTH-entry ring and lets the user
// browse newest-to-oldest. Define ROLL_RECORDER_STATS_EN to track the running maximum.
module roll_recorder #(
  parameter int DEPTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  roll_recorder_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic {
    S_LIVE   = 1'b0,
    S_BROWSE = 1'b1
  } state_t;

  state_t        r_state;
  logic [3:0]    r_mem [DEPTH];
  logic [IW-1:0] r_wr_ptr;
  logic [IW-1:0] r_rd_ptr;
  logic [IW-1:0] r_index;
  logic [CW-1:0] r_count;
  logic          r_busy_q;
  logic          r_armed;
  logic          r_new;
  logic [3:0]    r_display;

  logic          w_capture;
  logic          w_last;
  logic [IW-1:0] w_newest_ptr;
  logic [IW-1:0] w_step_ptr;
  logic [IW-1:0] w_step_idx;
  logic [CW-1:0] w_count_next;

  // r_armed stays low after reset until i_busy is seen low, so a roll already in
  // progress at reset release never produces a capture.
  always_comb begin
    w_capture    = r_busy_q & r_armed & ~bus.i_busy;
    w_newest_ptr = r_wr_ptr - IW'(1);
    w_last       = ({1'b0, r_index} == (r_count - CW'(1)));
    if (w_last) begin
      w_step_ptr = w_newest_ptr;
      w_step_idx = {IW{1'b0}};
    end else begin
      w_step_ptr = r_rd_ptr - IW'(1);
      w_step_idx = r_index + IW'(1);
    end
    if (r_count == CW'(DEPTH)) begin
      w_count_next = r_count;
    end else begin
      w_count_next = r_count + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= bus.i_value;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_LIVE;
      r_wr_ptr  <= {IW{1'b0}};
      r_rd_ptr  <= {IW{1'b0}};
      r_index   <= {IW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_busy_q  <= 1'b0;
      r_armed   <= 1'b0;
      r_new     <= 1'b0;
      r_display <= 4'd0;
    end else begin
      r_busy_q <= bus.i_busy;
      r_armed  <= r_armed | ~bus.i_busy;
      r_new    <= w_capture;
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + IW'(1);
        r_count  <= w_count_next;
      end
      case (r_state)
        S_LIVE: begin
          r_display <= bus.i_value;
          r_index   <= {IW{1'b0}};
          if (bus.i_recall && !bus.i_exit && (w_capture || (r_count != {CW{1'b0}}))) begin
            r_state <= S_BROWSE;
            // A capture in the same cycle is the newest entry; show it straight from the input.
            if (w_capture) begin
              r_rd_ptr <= r_wr_ptr;
            end else begin
              r_rd_ptr  <= w_newest_ptr;
              r_display <= r_mem[w_newest_ptr];
            end
          end
        end
        S_BROWSE: begin
          if (w_capture || bus.i_exit) begin
            r_state   <= S_LIVE;
            r_display <= bus.i_value;
            r_index   <= {IW{1'b0}};
          end else if (bus.i_recall) begin
            r_rd_ptr  <= w_step_ptr;
            r_index   <= w_step_idx;
            r_display <= r_mem[w_step_ptr];
          end
        end
        default: begin
          r_state <= S_LIVE;
        end
      endcase
    end
  end

  assign bus.o_display = r_display;
  assign bus.o_index   = r_index;
  assign bus.o_count   = r_count;
  assign bus.o_browse  = (r_state == S_BROWSE);
  assign bus.o_new     = r_new;

`ifdef ROLL_RECORDER_STATS_EN
  logic [3:0] r_max;

  // Updated on the capture edge so it becomes valid together with o_new.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_max <= 4'd0;
    end else if (w_capture && (bus.i_value > r_max)) begin
      r_max <= bus.i_value;
    end
  end

  assign bus.o_max = r_max;
`else
  assign bus.o_max = 4'd0;
`endif
endmodule

// File: tb/tb_roll_recorder.sv
// Self-checking bench for roll_recorder: directed scenarios plus randomized traffic
// compared against a history-queue model of the recorder.
module tb_roll_recorder;
  localparam int DEPTH = 8;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = IW + 1;

  logic i_clk;
  logic i_rst_n;
  int   checks;
  int   errors;

  roll_recorder_if #(.DEPTH(DEPTH)) bus ();

  roll_recorder #(.DEPTH(DEPTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Model: history of captured values (oldest first), browse flag and browse age.
  logic [3:0] hist[$];
  bit         m_browse;
  int         m_age;
  bit         m_prev_busy;
  bit         m_seen_low;
  logic [3:0] exp_disp;
  logic       exp_new;
  logic [3:0] m_max;

  function automatic logic [3:0] exp_max_out();
`ifdef ROLL_RECORDER_STATS_EN
    return m_max;
`else
    return 4'd0;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    m_browse    = 1'b0;
    m_age       = 0;
    m_prev_busy = 1'b0;
    m_seen_low  = 1'b0;
    exp_disp    = 4'd0;
    exp_new     = 1'b0;
    m_max       = 4'd0;
  endtask

  // Drive one cycle of inputs, advance the model, then move to just after the clock edge.
  task automatic tick(input logic [3:0] v, input logic b, input logic rc, input logic ex);
    bit cap;
    bus.i_value  = v;
    bus.i_busy   = b;
    bus.i_recall = rc;
    bus.i_exit   = ex;
    cap = m_prev_busy && !b && m_seen_low;
    m_seen_low  = m_seen_low || !b;
    m_prev_busy = b;
    exp_new = cap;
    if (cap) begin
      hist.push_back(v);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (v > m_max) m_max = v;
    end
    if (!m_browse) begin
      exp_disp = v;
      m_age    = 0;
      if (rc && !ex && hist.size() > 0) begin
        m_browse = 1'b1;
        exp_disp = hist[hist.size()-1];
      end
    end else if (cap || ex) begin
      m_browse = 1'b0;
      m_age    = 0;
      exp_disp = v;
    end else if (rc) begin
      m_age    = (m_age == hist.size() - 1) ? 0 : m_age + 1;
      exp_disp = hist[hist.size()-1-m_age];
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic roll(input logic [3:0] v);
    tick(4'($urandom), 1'b1, 1'b0, 1'b0);
    tick(4'($urandom), 1'b1, 1'b0, 1'b0);
    tick(v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic busy_level);
    bus.i_busy   = busy_level;
    bus.i_recall = 1'b0;
    bus.i_exit   = 1'b0;
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    m_prev_busy = busy_level;
    m_seen_low  = !busy_level;
    exp_disp    = bus.i_value;
  endtask

  task automatic test_reset();
    bus.i_value = 4'd0;
    do_reset(1'b0);
    roll(4'd11);
    tick(4'd6, 1'b0, 1'b1, 1'b0);
    // Asynchronous reset mid-cycle: outputs must clear with no clock edge.
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_display !== 4'd0 || bus.o_index !== IW'(0) || bus.o_count !== CW'(0) ||
        bus.o_browse !== 1'b0 || bus.o_new !== 1'b0 || bus.o_max !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got disp=%0d idx=%0d cnt=%0d br=%0b new=%0b max=%0d, need all 0",
               bus.o_display, bus.o_index, bus.o_count, bus.o_browse, bus.o_new, bus.o_max);
    end
    do_reset(1'b0);
  endtask

  task automatic test_three_rolls();
    int pulses;
    logic [3:0] vals [3];
    vals[0] = 4'd5; vals[1] = 4'd9; vals[2] = 4'd2;
    pulses = 0;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      roll(vals[i]);
      if (bus.o_new === 1'b1) pulses++;
      tick(4'd13 - 4'(i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.o_new !== 1'b0 || bus.o_display !== 4'd13 - 4'(i)) begin
        errors++;
        $display("FAIL live_track_%0d: got new=%0b disp=%0d, need new=0 disp=%0d",
                 i, bus.o_new, bus.o_display, 4'd13 - 4'(i));
      end
    end
    checks++;
    if (pulses != 3 || bus.o_count !== CW'(3)) begin
      errors++;
      $display("FAIL three_rolls: got pulses=%0d count=%0d, need 3/3", pulses, bus.o_count);
    end
  endtask

  task automatic test_recall_wrap();
    logic [3:0] want_d [4];
    int         want_i [4];
    want_d[0] = 4'd2; want_d[1] = 4'd9; want_d[2] = 4'd5; want_d[3] = 4'd2;
    want_i[0] = 0;    want_i[1] = 1;    want_i[2] = 2;    want_i[3] = 0;
    for (int i = 0; i < 4; i++) begin
      tick(4'd0, 1'b0, 1'b1, 1'b0);
      tick(4'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.o_display !== want_d[i] || bus.o_index !== IW'(want_i[i]) || bus.o_browse !== 1'b1) begin
        errors++;
        $display("FAIL recall_wrap_%0d: got disp=%0d idx=%0d br=%0b, need disp=%0d idx=%0d br=1",
                 i, bus.o_display, bus.o_index, bus.o_browse, want_d[i], want_i[i]);
      end
    end
    tick(4'd4, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.o_browse !== 1'b0 || bus.o_display !== 4'd4) begin
      errors++;
      $display("FAIL exit: got br=%0b disp=%0d, need br=0 disp=4", bus.o_browse, bus.o_display);
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) roll(4'(i));
    checks++;
    if (bus.o_count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL overflow_count: got %0d, need %0d", bus.o_count, DEPTH);
    end
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.o_display !== 4'd9 || bus.o_index !== IW'(0)) begin
      errors++;
      $display("FAIL overflow_newest: got disp=%0d idx=%0d, need 9/0", bus.o_display, bus.o_index);
    end
    for (int i = 0; i < DEPTH - 1; i++) tick(4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.o_display !== 4'd2 || bus.o_index !== IW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL overflow_oldest: got disp=%0d idx=%0d, need 2/%0d", bus.o_display, bus.o_index, DEPTH - 1);
    end
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.o_display !== 4'd9 || bus.o_index !== IW'(0)) begin
      errors++;
      $display("FAIL overflow_wrap: got disp=%0d idx=%0d, need 9/0", bus.o_display, bus.o_index);
    end
  endtask

  task automatic test_empty_recall();
    do_reset(1'b0);
    tick(4'd3, 1'b0, 1'b1, 1'b0);
    tick(4'd3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.o_browse !== 1'b0 || bus.o_count !== CW'(0)) begin
      errors++;
      $display("FAIL empty_recall: got br=%0b cnt=%0d, need 0/0", bus.o_browse, bus.o_count);
    end
  endtask

  task automatic test_capture_in_browse();
    do_reset(1'b0);
    roll(4'd1);
    roll(4'd8);
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    roll(4'd7);
    checks++;
    if (bus.o_browse !== 1'b0 || bus.o_count !== CW'(3) || bus.o_new !== 1'b1) begin
      errors++;
      $display("FAIL capture_in_browse: got br=%0b cnt=%0d new=%0b, need 0/3/1",
               bus.o_browse, bus.o_count, bus.o_new);
    end
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.o_display !== 4'd7 || bus.o_index !== IW'(0) || bus.o_browse !== 1'b1) begin
      errors++;
      $display("FAIL capture_then_recall: got disp=%0d idx=%0d br=%0b, need 7/0/1",
               bus.o_display, bus.o_index, bus.o_browse);
    end
  endtask

  task automatic test_coincide();
    do_reset(1'b0);
    roll(4'd3);
    tick(4'd10, 1'b1, 1'b0, 1'b0);
    tick(4'd14, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.o_browse !== 1'b1 || bus.o_display !== 4'd14 || bus.o_index !== IW'(0) ||
        bus.o_count !== CW'(2)) begin
      errors++;
      $display("FAIL recall_with_capture: got br=%0b disp=%0d idx=%0d cnt=%0d, need 1/14/0/2",
               bus.o_browse, bus.o_display, bus.o_index, bus.o_count);
    end
    tick(4'd6, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.o_browse !== 1'b0 || bus.o_display !== 4'd6) begin
      errors++;
      $display("FAIL exit_priority: got br=%0b disp=%0d, need 0/6", bus.o_browse, bus.o_display);
    end
  endtask

  task automatic test_reset_during_roll();
    do_reset(1'b1);
    tick(4'd5, 1'b1, 1'b0, 1'b0);
    tick(4'd5, 1'b0, 1'b0, 1'b0);
    tick(4'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== CW'(0) || bus.o_new !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_roll: got cnt=%0d new=%0b, need 0/0", bus.o_count, bus.o_new);
    end
    roll(4'd3);
    roll(4'd12);
    roll(4'd4);
    checks++;
    if (bus.o_count !== CW'(3) || bus.o_max !== exp_max_out()) begin
      errors++;
      $display("FAIL stats_max: got cnt=%0d max=%0d, need 3/%0d", bus.o_count, bus.o_max, exp_max_out());
    end
  endtask

  task automatic test_random();
    logic b;
    logic rc;
    logic ex;
    b = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) b = ~b;
      ex = ($urandom_range(9) == 0);
      rc = !ex && ($urandom_range(3) == 0);
      tick(4'($urandom), b, rc, ex);
      checks++;
      if (bus.o_display !== exp_disp || bus.o_index !== IW'(m_age) ||
          bus.o_count !== CW'(hist.size()) || bus.o_browse !== m_browse ||
          bus.o_new !== exp_new || bus.o_max !== exp_max_out()) begin
        errors++;
        $display("FAIL random_%0d: got disp=%0d idx=%0d cnt=%0d br=%0b new=%0b max=%0d, need %0d/%0d/%0d/%0b/%0b/%0d",
                 i, bus.o_display, bus.o_index, bus.o_count, bus.o_browse, bus.o_new, bus.o_max,
                 exp_disp, m_age, hist.size(), m_browse, exp_new, exp_max_out());
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    i_rst_n      = 1'b0;
    bus.i_value  = 4'd0;
    bus.i_busy   = 1'b0;
    bus.i_recall = 1'b0;
    bus.i_exit   = 1'b0;
    #2;
    test_reset();
    test_three_rolls();
    test_recall_wrap();
    test_overflow();
    test_empty_recall();
    test_capture_in_browse();
    test_coincide();
    test_reset_during_roll();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/roll_recorder.md
ROLL_RECORDER -- requirements
Module: roll_recorder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, history entries; power of two, 2..16; IW = clog2(DEPTH).
REQ-002 SHALL have i_clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have i_value  input  4  live random value from generator.
REQ-005 SHALL have i_busy  input  1  high while generator is rolling, synchronous to i_clk.
REQ-006 SHALL have i_recall  input  1  one-cycle pulse: enter browse, or step to the next-older entry.
REQ-007 SHALL have i_exit  input  1  one-cycle pulse: return to live view.
REQ-008 SHALL have o_display  output  4  registered value shown to user.
REQ-009 SHALL have o_index  output  IW  age of browsed entry, 0 = newest; 0 in live view.
REQ-010 SHALL have o_count  output  IW+1  number of valid entries, 0..DEPTH.
REQ-011 SHALL have o_browse  output  1  high in browse state.
REQ-012 SHALL have o_new  output  1  one-cycle pulse on the cycle after each capture.
REQ-013 SHALL have o_max  output  4  running maximum of captured values (see Configuration).

Function
REQ-014 SHALL register i_busy once (busy_q); capture event = busy_q high and i_busy low (falling edge).
REQ-015 SHALL, on capture, write i_value into mem[wr_ptr], advance wr_ptr modulo DEPTH, and increment count, saturating at DEPTH.
REQ-016 SHALL, once full, overwrite the oldest entry; o_count stays DEPTH.
REQ-017 SHALL assert o_new exactly one cycle, in the cycle following the capture edge.
REQ-018 SHALL implement two states, S_LIVE and S_BROWSE.
REQ-019 SHALL, in S_LIVE, load o_display with i_value every cycle (one-cycle latency) and hold o_index at 0.
REQ-020 SHALL, in S_LIVE, on i_recall with count > 0, go to S_BROWSE, set rd_ptr = newest entry, and set o_index = 0.
REQ-021 SHALL ignore i_recall in S_LIVE when count = 0.
REQ-022 SHALL, in S_BROWSE, on i_recall, decrement rd_ptr modulo DEPTH and increment o_index; if o_index = count-1, wrap to the newest entry and set o_index = 0.
REQ-023 SHALL, in S_BROWSE, drive o_display with mem[rd_ptr] on the cycle after any rd_ptr change.
REQ-024 SHALL, on i_exit in S_BROWSE, go to S_LIVE; i_exit in S_LIVE has no effect.
REQ-025 SHALL force S_LIVE on a capture during S_BROWSE; the capture is stored normally.
REQ-026 SHALL give i_exit priority when i_exit and i_recall coincide.
REQ-027 SHALL, when i_recall and a capture coincide in S_LIVE, store the capture first and enter S_BROWSE showing the new value at o_index 0.
REQ-028 SHALL capture normally regardless of i_recall/i_exit activity; storage is never blocked.

Reset
REQ-029 SHALL clear on reset: state = S_LIVE, wr_ptr = 0, rd_ptr = 0, count = 0, busy_q = 0.
REQ-030 SHALL clear on reset: o_display = 0, o_index = 0, o_new = 0, o_browse = 0, o_max = 0.
REQ-031 SHALL leave memory contents undefined after reset; they are unreachable until rewritten because count = 0.
REQ-032 SHALL, on reset during a roll, suppress any capture until a new high-to-low i_busy transition occurs.

Configuration
REQ-033 SHALL use macro ROLL_RECORDER_STATS_EN.
REQ-034 SHALL, when the macro is defined, update o_max to max(o_max, i_value) on each capture, registered, valid together with o_new.
REQ-035 SHALL, when the macro is undefined, tie o_max to 0 and instantiate no compare logic; the port remains present.

Verification
REQ-036 SHALL verify: three rolls ending with values 5, 9, 2 -> o_count = 3, o_new pulses three times, live o_display tracks i_value.
REQ-037 SHALL verify: then i_recall x4 -> o_display 2, 9, 5, 2 with o_index 0, 1, 2, 0 (wrap).
REQ-038 SHALL verify: DEPTH = 8, ten captures of values 0..9, then browse -> o_count = 8, oldest visible entry is 2, newest is 9.
REQ-039 SHALL verify: i_recall with o_count = 0 -> o_browse stays 0.
REQ-040 SHALL verify: in browse, capture of 7 -> o_browse drops the next cycle, o_count increments, and recall shows 7 at index 0.
REQ-041 SHALL verify: reset asserted while i_busy is high, then i_busy falls -> no capture, o_count = 0; with ROLL_RECORDER_STATS_EN, captures 3, 12, 4 -> o_max = 12.
